// File: rtl/digit_text_renderer.sv
// Two-stage digit overlay: raster position -> glyph ROM address -> pixel.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero slots.
module digit_text_renderer #(
  parameter int NUM_DIGITS = 4,
  parameter int X0 = 200,
  parameter int Y0 = 100,
  parameter int SCALE_LOG2 = 2,
  parameter int GAP = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  input  logic          video_on,
  input  logic          frame_tick,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [3:0]    wr_digit,
  output logic [3:0]    glyph_digit,
  output logic [2:0]    glyph_row,
  input  logic [4:0]    glyph_code,
  output logic          pixel_on,
  output logic          pixel_valid
);

  localparam int CELL = 5 + GAP;
  localparam int W = (NUM_DIGITS * CELL) << SCALE_LOG2;
  localparam int H = 6 << SCALE_LOG2;
  localparam logic [9:0] X0V = 10'(X0);
  localparam logic [9:0] Y0V = 10'(Y0);
  localparam logic [9:0] WV = 10'(W);
  localparam logic [9:0] HV = 10'(H);
  localparam logic [9:0] CV = 10'(CELL);

  logic [3:0] shadow_q [NUM_DIGITS];
  logic [3:0] shadow_d [NUM_DIGITS];
  logic [3:0] active_q [NUM_DIGITS];

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (int'(wr_idx) < NUM_DIGITS))
      shadow_d[wr_idx] = wr_digit;
  end

  // Commit takes the post-write bank so a same-cycle write is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (frame_tick)
        active_q <= shadow_d;
    end
  end

  logic [9:0]    rx;
  logic [9:0]    ry;
  logic [9:0]    gx;
  logic [9:0]    col;
  logic [IW-1:0] slot;
  logic          in_box;
  logic [3:0]    cur;
  logic          lz_blank;
  logic          draw;

  assign rx = pix_x - X0V;
  assign ry = pix_y - Y0V;
  assign gx = rx >> SCALE_LOG2;
  assign col = gx % CV;
  assign slot = IW'(gx / CV);
  assign in_box = video_on && (pix_x >= X0V) && (rx < WV)
                  && (pix_y >= Y0V) && (ry < HV);
  assign cur = in_box ? active_q[slot] : 4'd0;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic acc;

  always_comb begin
    lz = '0;
    acc = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      acc = acc && (active_q[i] == 4'd0);
      lz[i] = acc;
    end
  end

  assign lz_blank = lz[slot];
`else
  assign lz_blank = 1'b0;
`endif

  assign draw = in_box && (col < 10'd5) && (cur <= 4'd9) && !lz_blank;

  logic [2:0] col_q;
  logic       draw_q;
  logic       vld_q;
  logic [4:0] code_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_digit <= '0;
      glyph_row   <= '0;
      col_q       <= '0;
      draw_q      <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      glyph_digit <= cur;
      glyph_row   <= in_box ? 3'(ry >> SCALE_LOG2) : 3'd0;
      col_q       <= col[2:0];
      draw_q      <= draw;
      vld_q       <= video_on;
    end
  end

  // Shift the selected column into bit 4 (leftmost dot).
  assign code_sh = glyph_code << col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= draw_q && code_sh[4];
      pixel_valid <= vld_q;
    end
  end

endmodule

// File: tb/tb_digit_text_renderer.sv
// Scoreboard bench for digit_text_renderer with a pixel-level reference.
// Set LEADING_ZERO_BLANK_EN to exercise leading-zero blanking.
module tb_digit_text_renderer;

  localparam int ND = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int RX = 276;
`else
  localparam int RX = 204;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       video_on = 1'b0;
  logic       frame_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [3:0] wr_digit = '0;
  logic [3:0] glyph_digit;
  logic [2:0] glyph_row;
  logic [4:0] glyph_code;
  logic       pixel_on;
  logic       pixel_valid;

  always #5 clk = ~clk;

  digit_text_renderer dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y),
    .video_on(video_on), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_digit(wr_digit),
    .glyph_digit(glyph_digit), .glyph_row(glyph_row),
    .glyph_code(glyph_code),
    .pixel_on(pixel_on), .pixel_valid(pixel_valid)
  );

  logic [4:0] font [60];
  initial font = '{
    5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b01110,
    5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b01110,
    5'b01110, 5'b10001, 5'b00010, 5'b00100, 5'b01000, 5'b11111,
    5'b11110, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110,
    5'b01000, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010,
    5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b10001, 5'b01110,
    5'b01110, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110,
    5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000,
    5'b01110, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110,
    5'b01110, 5'b10001, 5'b01111, 5'b00001, 5'b00001, 5'b01110
  };

  assign glyph_code = (glyph_digit <= 4'd9 && glyph_row < 3'd6)
    ? font[int'(glyph_digit) * 6 + int'(glyph_row)] : 5'd0;

  typedef struct { logic on; logic vld; } pexp_t;
  typedef struct { int d; int r; } gexp_t;

  pexp_t pq[$];
  gexp_t gq[$];
  int m_shadow[ND];
  int m_active[ND];
  bit mon_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string n, int a, int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  function automatic bit lz_blank(int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot >= ND - 1) return 1'b0;
    for (int i = 0; i <= slot; i++)
      if (m_active[i] != 0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void ref_pix(input int x, input int y, input bit vo,
                                  output bit on, output int dv, output int rw);
    int rx, ry, gx, slot, col;
    logic [4:0] code;
    rx = x - 200;
    ry = y - 100;
    on = 1'b0;
    dv = 0;
    rw = 0;
    if (vo && rx >= 0 && rx < 96 && ry >= 0 && ry < 24) begin
      gx = rx / 4;
      slot = gx / 6;
      col = gx % 6;
      rw = ry / 4;
      dv = m_active[slot];
      if (col < 5 && dv <= 9 && !lz_blank(slot)) begin
        code = font[dv * 6 + rw];
        on = code[4 - col];
      end
    end
  endfunction

  task automatic pix(input int x, input int y, input bit vo,
                     input bit we = 0, input int idx = 0,
                     input int d = 0, input bit ft = 0);
    bit on;
    int dv, rw;
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_on = vo;
    wr_en = we;
    wr_idx = 2'(idx);
    wr_digit = 4'(d);
    frame_tick = ft;
    ref_pix(x, y, vo, on, dv, rw);
    pq.push_back('{on: on, vld: vo});
    gq.push_back('{d: dv, r: rw});
    if (we) m_shadow[idx] = d;
    if (ft) m_active = m_shadow;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pix(0, 0, 1'b0);
  endtask

  task automatic scan(int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        pix(x, y, 1'b1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    pix_x = '0;
    pix_y = '0;
    video_on = 1'b0;
    wr_en = 1'b0;
    frame_tick = 1'b0;
    #1;
    chk("rst_pixel_on", int'(pixel_on), 0);
    chk("rst_pixel_valid", int'(pixel_valid), 0);
    chk("rst_glyph_digit", int'(glyph_digit), 0);
    chk("rst_glyph_row", int'(glyph_row), 0);
    pq.delete();
    gq.delete();
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    pq.push_back('{on: 1'b0, vld: 1'b0});
    pq.push_back('{on: 1'b0, vld: 1'b0});
    gq.push_back('{d: 0, r: 0});
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    pexp_t pe;
    gexp_t ge;
    if (mon_en) begin
      while (pq.size() > 2) begin
        pe = pq.pop_front();
        chk("pixel_on", int'(pixel_on), int'(pe.on));
        chk("pixel_valid", int'(pixel_valid), int'(pe.vld));
      end
      while (gq.size() > 1) begin
        ge = gq.pop_front();
        chk("glyph_digit", int'(glyph_digit), ge.d);
        chk("glyph_row", int'(glyph_row), ge.r);
      end
    end
  end

  initial begin
    do_reset();
    // all-zero bank after reset, then reset while pixel_on is high
    repeat (3) pix(RX, 100, 1'b1);
    chk("pre_reset_on", int'(pixel_on), 1);
    do_reset();
    pix(RX, 100, 1'b1);
    idle();
    idle();

    pix(0, 0, 1'b0, 1'b1, 0, 4, 1'b0);
    pix(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    scan(196, 227, 100, 100);
    scan(196, 227, 112, 115);
    scan(196, 227, 124, 124);

    pix(0, 0, 1'b0, 1'b1, 1, 7, 1'b0);
    scan(224, 243, 100, 123);
    pix(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    scan(224, 243, 100, 123);
    pix(0, 0, 1'b0, 1'b1, 1, 3, 1'b1);
    scan(224, 243, 100, 111);

    pix(0, 0, 1'b0, 1'b1, 2, 12, 1'b1);
    scan(244, 271, 99, 124);

`ifdef LEADING_ZERO_BLANK_EN
    pix(0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    pix(0, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    pix(0, 0, 1'b0, 1'b1, 2, 4, 1'b0);
    pix(0, 0, 1'b0, 1'b1, 3, 0, 1'b1);
    scan(198, 297, 99, 124);
    pix(0, 0, 1'b0, 1'b1, 2, 0, 1'b1);
    scan(198, 297, 99, 124);
`endif

    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
      pix(int'($urandom_range(190, 310)), int'($urandom_range(95, 130)),
          $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
          int'($urandom_range(0, 3)), d, $urandom_range(0, 39) == 0);
    end

    idle();
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
